// File: rtl/core_cascade_pkg.sv
// Types and constants shared between the block dispatcher and the per-core sequencers.
package core_cascade_pkg;

  localparam int unsigned BLOCK_ID_W = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_DRAIN,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/core_block_sequencer.sv
// Per-core block sequencer: accepts one block, issues its threads, tracks retirement, holds done.
// Optional SEQ_PERF_EN adds a saturating block_cycles counter output.
module core_block_sequencer
  import core_cascade_pkg::*;
#(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  localparam int unsigned LW = $clog2(THREADS_PER_BLOCK)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         block_reset,
  input  logic                         start,
  input  logic [BLOCK_ID_W-1:0]        block_id,
  input  logic [LW:0]                  thread_count,
  output logic                         done,
  output logic                         thread_valid,
  input  logic                         thread_ready,
  output logic [LW-1:0]                thread_lane,
  output logic [BLOCK_ID_W+LW-1:0]     thread_gid,
  input  logic                         retire_valid,
  input  logic [LW-1:0]                retire_lane,
  output logic [THREADS_PER_BLOCK-1:0] active_mask,
  output logic                         retire_err
`ifdef SEQ_PERF_EN
  ,
  output logic [15:0]                  block_cycles
`endif
);

  localparam logic [LW:0] TpbCnt = THREADS_PER_BLOCK[LW:0];
  localparam logic [LW:0] CntOne = 1;

  seq_state_t                   state_q;
  logic [BLOCK_ID_W-1:0]        block_id_q;
  logic [LW:0]                  count_q;
  logic [LW:0]                  issue_cnt_q;
  logic [LW:0]                  retire_cnt_q;
  logic [THREADS_PER_BLOCK-1:0] active_mask_q;
  logic                         retire_err_q;
  logic                         done_q;
  logic                         thread_valid_q;
  logic [LW-1:0]                thread_lane_q;
  logic [BLOCK_ID_W+LW-1:0]     thread_gid_q;

  logic                         issue_fire;
  logic                         retire_ok;
  logic [LW-1:0]                issue_lane;
  logic [LW-1:0]                next_lane;
  logic [LW:0]                  issue_cnt_inc;
  logic [LW:0]                  retire_cnt_next;
  logic [LW:0]                  clamped_count;
  logic [THREADS_PER_BLOCK-1:0] mask_next;

  always_comb begin
    issue_lane    = issue_cnt_q[LW-1:0];
    next_lane     = issue_lane + 1'b1;
    issue_cnt_inc = issue_cnt_q + CntOne;
    issue_fire    = (state_q == SEQ_ISSUE) && thread_valid_q && thread_ready;
    retire_ok     = retire_valid && active_mask_q[retire_lane];
    clamped_count = (thread_count > TpbCnt) ? TpbCnt : thread_count;
    retire_cnt_next = retire_ok ? (retire_cnt_q + CntOne) : retire_cnt_q;
    // Retire is judged on the pre-issue mask, so retiring the lane issued this cycle is an error.
    mask_next = active_mask_q;
    if (retire_ok) begin
      mask_next[retire_lane] = 1'b0;
    end
    if (issue_fire) begin
      mask_next[issue_lane] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || block_reset) begin
      state_q        <= SEQ_IDLE;
      block_id_q     <= '0;
      count_q        <= '0;
      issue_cnt_q    <= '0;
      retire_cnt_q   <= '0;
      active_mask_q  <= '0;
      retire_err_q   <= 1'b0;
      done_q         <= 1'b0;
      thread_valid_q <= 1'b0;
      thread_lane_q  <= '0;
      thread_gid_q   <= '0;
    end else begin
      active_mask_q <= mask_next;
      retire_cnt_q  <= retire_cnt_next;
      if (retire_valid && !retire_ok) begin
        retire_err_q <= 1'b1;
      end
      unique case (state_q)
        SEQ_IDLE: begin
          if (start) begin
            block_id_q <= block_id;
            count_q    <= clamped_count;
            if (clamped_count == '0) begin
              state_q <= SEQ_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q        <= SEQ_ISSUE;
              thread_valid_q <= 1'b1;
              thread_lane_q  <= '0;
              thread_gid_q   <= {block_id, {LW{1'b0}}};
            end
          end
        end
        SEQ_ISSUE: begin
          if (issue_fire) begin
            issue_cnt_q <= issue_cnt_inc;
            if (issue_cnt_inc == count_q) begin
              thread_valid_q <= 1'b0;
              thread_lane_q  <= '0;
              thread_gid_q   <= '0;
              if (retire_cnt_next == count_q) begin
                state_q <= SEQ_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= SEQ_DRAIN;
              end
            end else begin
              thread_lane_q <= next_lane;
              thread_gid_q  <= {block_id_q, next_lane};
            end
          end
        end
        SEQ_DRAIN: begin
          if (retire_cnt_next == count_q) begin
            state_q <= SEQ_DONE;
            done_q  <= 1'b1;
          end
        end
        SEQ_DONE: begin
          state_q <= SEQ_DONE;
        end
        default: begin
          state_q <= SEQ_IDLE;
        end
      endcase
    end
  end

  assign done         = done_q;
  assign thread_valid = thread_valid_q;
  assign thread_lane  = thread_lane_q;
  assign thread_gid   = thread_gid_q;
  assign active_mask  = active_mask_q;
  assign retire_err   = retire_err_q;

`ifdef SEQ_PERF_EN
  logic [15:0] block_cycles_q;

  // An empty block reaches done on the very next edge, so it is loaded with 1 at acceptance.
  always_ff @(posedge clk) begin
    if (reset || block_reset) begin
      block_cycles_q <= '0;
    end else if (state_q == SEQ_IDLE) begin
      if (start) begin
        block_cycles_q <= (clamped_count == '0) ? 16'd1 : 16'd0;
      end
    end else if (state_q != SEQ_DONE && block_cycles_q != 16'hFFFF) begin
      block_cycles_q <= block_cycles_q + 16'd1;
    end
  end

  assign block_cycles = block_cycles_q;
`endif

endmodule

// File: tb/tb_core_block_sequencer.sv
// Scoreboard bench for core_block_sequencer (TPB=4): queued expected gids plus a lane-set model.
module tb_core_block_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       block_reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] block_id = '0;
  logic [2:0] thread_count = '0;
  logic       done;
  logic       thread_valid;
  logic       thread_ready = 1'b0;
  logic [1:0] thread_lane;
  logic [9:0] thread_gid;
  logic       retire_valid = 1'b0;
  logic [1:0] retire_lane = '0;
  logic [3:0] active_mask;
  logic       retire_err;
`ifdef SEQ_PERF_EN
  logic [15:0] block_cycles;
`endif

  core_block_sequencer #(.THREADS_PER_BLOCK(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .block_reset  (block_reset),
    .start        (start),
    .block_id     (block_id),
    .thread_count (thread_count),
    .done         (done),
    .thread_valid (thread_valid),
    .thread_ready (thread_ready),
    .thread_lane  (thread_lane),
    .thread_gid   (thread_gid),
    .retire_valid (retire_valid),
    .retire_lane  (retire_lane),
    .active_mask  (active_mask),
    .retire_err   (retire_err)
`ifdef SEQ_PERF_EN
    ,
    .block_cycles (block_cycles)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;
  int exp_gid[$];

  // Reference model: values the DUT should show during the current cycle.
  bit       m_busy = 1'b0;
  bit       m_done = 1'b0;
  bit       m_err = 1'b0;
  int       m_bid = 0;
  int       m_count = 0;
  int       m_issued = 0;
  int       m_retired = 0;
  logic [3:0] m_mask = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    return m_busy && (m_issued < m_count);
  endfunction

  // Monitor: compare this cycle's outputs, pop the scoreboard on a handshake, then advance the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("done", int'(done), int'(m_done));
      chk("thread_valid", int'(thread_valid), int'(m_valid()));
      chk("active_mask", int'(active_mask), int'(m_mask));
      chk("retire_err", int'(retire_err), int'(m_err));
      if (m_valid()) begin
        chk("thread_lane", int'(thread_lane), m_issued);
      end else if (!m_busy && !m_done) begin
        chk("idle_lane", int'(thread_lane), 0);
        chk("idle_gid", int'(thread_gid), 0);
      end
      if (!reset && !block_reset && thread_valid && thread_ready) begin
        if (exp_gid.size() == 0) begin
          chk("unexpected_issue", int'(thread_gid), -1);
        end else begin
          chk("issued_gid", int'(thread_gid), exp_gid.pop_front());
        end
      end
    end
    if (reset || block_reset) begin
      m_busy = 0; m_done = 0; m_err = 0; m_bid = 0; m_count = 0;
      m_issued = 0; m_retired = 0; m_mask = '0;
    end else begin
      bit issue_now;
      issue_now = m_valid() && thread_ready;
      if (retire_valid) begin
        if (m_mask[retire_lane]) begin
          m_mask[retire_lane] = 1'b0;
          m_retired++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (issue_now) begin
        m_mask[m_issued] = 1'b1;
        m_issued++;
      end
      if (!m_busy && !m_done) begin
        if (start) begin
          m_bid = int'(block_id);
          m_count = (int'(thread_count) > 4) ? 4 : int'(thread_count);
          m_issued = 0;
          m_retired = 0;
          if (m_count == 0) m_done = 1'b1;
          else m_busy = 1'b1;
        end
      end else if (m_busy && m_issued == m_count && m_retired == m_count) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pick_retire(input int pct, input int bad_pct);
    retire_valid = 1'b0;
    if (bad_pct > 0 && $urandom_range(0, 99) < bad_pct) begin
      retire_valid = 1'b1;
      retire_lane = 2'($urandom_range(0, 3));
    end else if (m_mask != 0 && $urandom_range(0, 99) < pct) begin
      int l = $urandom_range(0, 3);
      for (int k = 0; k < 4 && !m_mask[l]; k++) l = (l + 1) % 4;
      retire_valid = 1'b1;
      retire_lane = 2'(l);
    end
  endtask

  // rdy: -1 selects the 1,0,0 ready pattern; otherwise percentage. abort>0 resets mid-block.
  task automatic run_block(input int bid, input int tc, input int rdy, input int ret_pct,
                           input int bad_lane, input int bad_pct, input int abort);
    int cnt;
    int n = 0;
    cnt = (tc > 4) ? 4 : tc;
    for (int l = 0; l < cnt; l++) exp_gid.push_back(bid * 4 + l);
    block_id = 8'(bid);
    thread_count = 3'(tc);
    start = 1'b1;
    thread_ready = 1'b0;
    retire_valid = 1'b0;
    step();
    while (!m_done && n < 300) begin
      if (abort > 0 && n == abort) begin
        start = 1'b0;
        retire_valid = 1'b0;
        reset = 1'b1;
        step();
        exp_gid.delete();
        reset = 1'b0;
        return;
      end
      if (rdy < 0) thread_ready = (n % 3 == 0);
      else thread_ready = ($urandom_range(0, 99) < rdy);
      pick_retire(ret_pct, bad_pct);
      if (n == 0 && bad_lane >= 0) begin
        thread_ready = 1'b0;
        retire_valid = 1'b1;
        retire_lane = 2'(bad_lane);
      end
      step();
      n++;
    end
    if (n >= 300) chk("done_timeout", n, 0);
    retire_valid = 1'b0;
    thread_ready = 1'b1;
    repeat (3) step();
    start = 1'b0;
    block_reset = 1'b1;
    step();
    block_reset = 1'b0;
    chk("leftover_gids", exp_gid.size(), 0);
  endtask

  initial begin
    step();
    checking = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_done", int'(done), 0);
    chk("reset_mask", int'(active_mask), 0);
    chk("reset_gid", int'(thread_gid), 0);

    run_block(3, 4, 100, 60, -1, 0, 0);
    run_block(7, 2, 100, 50, -1, 0, 0);
    run_block(9, 0, 100, 50, -1, 0, 0);
    run_block(11, 4, -1, 40, -1, 0, 0);
    run_block(5, 4, 70, 50, 2, 0, 0);

    // Abandon a block in DRAIN with lanes 1 and 2 still in flight.
    for (int l = 0; l < 4; l++) exp_gid.push_back(6 * 4 + l);
    block_id = 8'd6;
    thread_count = 3'd4;
    start = 1'b1;
    thread_ready = 1'b1;
    step();
    for (int k = 0; k < 20 && m_issued < 4; k++) step();
    thread_ready = 1'b0;
    retire_valid = 1'b1;
    retire_lane = 2'd0;
    step();
    retire_lane = 2'd3;
    step();
    retire_valid = 1'b0;
    chk("drain_mask", int'(active_mask), 6);
    start = 1'b0;
    block_reset = 1'b1;
    step();
    block_reset = 1'b0;
    chk("post_reset_mask", int'(active_mask), 0);
    chk("post_reset_done", int'(done), 0);
    run_block(1, 4, 100, 50, -1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      run_block(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                int'($urandom_range(30, 100)), int'($urandom_range(20, 90)), -1, 3,
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0);
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
